// File: rtl/ci_window_mean_if.sv
// Handshake and window bus between the upstream hold stage and ci_window_mean.
interface ci_window_mean_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIZE  = 25
);
    logic             i_start;
    logic [WIDTH-1:0] i_win [SIZE];
    logic             o_busy;
    logic             o_valid;
    logic [WIDTH-1:0] o_mean;
    logic             o_ci;

    // Upstream side: requests a run and holds the window.
    modport master (
        output i_start,
        output i_win,
        input  o_busy,
        input  o_valid,
        input  o_mean,
        input  o_ci
    );

    // Block side: consumes the window and reports the result.
    modport slave (
        input  i_start,
        input  i_win,
        output o_busy,
        output o_valid,
        output o_mean,
        output o_ci
    );
endinterface

// File: rtl/ci_window_mean.sv
// Window mean and center-indicator: sequentially sums SIZE pixels, divides by SIZE
// with a bit-serial restoring divider, and flags whether the center pixel reaches the mean.
module ci_window_mean #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SIZE  = 25
) (
    input logic             i_clk,
    input logic             i_rst_n,
    ci_window_mean_if.slave bus
);
    localparam int unsigned SUMW = WIDTH + $clog2(SIZE);
    localparam int unsigned IDXW = $clog2(SIZE);
    localparam int unsigned DIVW = $clog2(SUMW);
    // One counter serves both the element index and the quotient bit count.
    localparam int unsigned CNTW = (IDXW > DIVW) ? IDXW : DIVW;

    localparam logic [CNTW-1:0] ACC_LAST   = CNTW'(SIZE - 1);
    localparam logic [CNTW-1:0] DIV_LAST   = CNTW'(SUMW - 1);
    localparam logic [SUMW-1:0] DIVISOR    = SUMW'(SIZE);
    localparam logic [IDXW-1:0] CENTER_SEL = IDXW'(SIZE / 2);

    typedef enum logic [1:0] {StIdle, StAcc, StDiv, StDone} state_e;

    state_e           state_q, state_d;
    logic [SUMW-1:0]  sum_q, sum_d;
    logic [CNTW-1:0]  idx_q, idx_d;
    logic [SUMW-1:0]  quot_q, quot_d;
    logic [SUMW-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0] center_q, center_d;
    logic [WIDTH-1:0] mean_q, mean_d;
    logic             ci_q, ci_d;

    logic [IDXW-1:0]  acc_sel;
    logic [SUMW-1:0]  elem_ext;
    logic [SUMW-1:0]  rem_shift;
    logic             rem_ge;
    logic [SUMW-1:0]  quot_next;

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; i_start only matters in IDLE, so it is ignored while busy.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.i_start) state_d = StAcc;
            StAcc:   if (idx_q == ACC_LAST) state_d = StDiv;
            StDiv:   if (idx_q == DIV_LAST) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state; result registers hold between runs.
    always_comb begin
        bus.o_busy  = (state_q != StIdle);
        bus.o_valid = (state_q == StDone);
        bus.o_mean  = mean_q;
        bus.o_ci    = ci_q;
    end

    // Datapath next-state: accumulate, then shift-subtract one quotient bit per cycle.
    always_comb begin
        sum_d    = sum_q;
        idx_d    = idx_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        center_d = center_q;
        mean_d   = mean_q;
        ci_d     = ci_q;

        acc_sel  = idx_q[IDXW-1:0];
        elem_ext = SUMW'(bus.i_win[acc_sel]);
        // rem_q < SIZE, so dropping its MSB on the shift never loses a set bit.
        rem_shift = {rem_q[SUMW-2:0], sum_q[SUMW-1]};
        rem_ge    = (rem_shift >= DIVISOR);
        quot_next = {quot_q[SUMW-2:0], rem_ge};

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    sum_d    = '0;
                    idx_d    = '0;
                    center_d = bus.i_win[CENTER_SEL];
                end
            end
            StAcc: begin
                sum_d = sum_q + elem_ext;
                if (idx_q == ACC_LAST) begin
                    idx_d  = '0;
                    rem_d  = '0;
                    quot_d = '0;
                end else begin
                    idx_d = idx_q + CNTW'(1);
                end
            end
            StDiv: begin
                // sum_q is consumed MSB first as the dividend shifts out.
                sum_d  = sum_q << 1;
                rem_d  = rem_ge ? (rem_shift - DIVISOR) : rem_shift;
                quot_d = quot_next;
                idx_d  = idx_q + CNTW'(1);
                if (idx_q == DIV_LAST) begin
                    mean_d = quot_next[WIDTH-1:0];
                    ci_d   = (center_q >= quot_next[WIDTH-1:0]);
                end
            end
            StDone: begin
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset aborts any run and clears the visible result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sum_q    <= '0;
            idx_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            center_q <= '0;
            mean_q   <= '0;
            ci_q     <= 1'b0;
        end else begin
            sum_q    <= sum_d;
            idx_q    <= idx_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            center_q <= center_d;
            mean_q   <= mean_d;
            ci_q     <= ci_d;
        end
    end
endmodule

// File: tb/tb_ci_window_mean.sv
// Self-checking bench for ci_window_mean: directed and random windows against an
// arithmetic reference (plain sum / SIZE), plus start-ignore, back-to-back and reset cases.
module tb_ci_window_mean;
    localparam int unsigned W     = 8;
    localparam int unsigned N     = 25;
    // SIZE accumulate cycles + SUMW divide cycles + the DONE cycle.
    localparam int unsigned LAT   = N + W + $clog2(N) + 1;
    localparam int unsigned LIMIT = 200;

    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [W-1:0] cur_win [N];

    ci_window_mean_if #(.WIDTH(W), .SIZE(N)) bus ();

    ci_window_mean #(.WIDTH(W), .SIZE(N)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net in case something waits forever.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_mean();
        int unsigned s = 0;
        foreach (cur_win[k]) s += int'(cur_win[k]);
        return s / N;
    endfunction

    function automatic int unsigned model_ci();
        return (int'(cur_win[N/2]) >= model_mean()) ? 1 : 0;
    endfunction

    // One complete run of cur_win; optional extra start pulses at run cycles 5 and 20.
    task automatic do_run(input string tag, input bit pulse_mid);
        int          cyc;
        int          busy_gaps;
        int unsigned exp_mean;
        int unsigned exp_ci;
        exp_mean  = model_mean();
        exp_ci    = model_ci();
        busy_gaps = 0;
        bus.i_win = cur_win;
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        cyc = 1;
        while (!bus.o_valid && cyc < LIMIT) begin
            if (!bus.o_busy) busy_gaps++;
            bus.i_start = (pulse_mid && (cyc == 5 || cyc == 20));
            @(negedge clk);
            cyc++;
        end
        bus.i_start = 1'b0;
        check($sformatf("%s.latency", tag), cyc, LAT);
        check($sformatf("%s.mean", tag), bus.o_mean, exp_mean);
        check($sformatf("%s.ci", tag), bus.o_ci, exp_ci);
        check($sformatf("%s.busy_done", tag), bus.o_busy, 1);
        check($sformatf("%s.busy_gaps", tag), busy_gaps, 0);
        @(negedge clk);
        check($sformatf("%s.valid_drop", tag), bus.o_valid, 0);
        check($sformatf("%s.idle", tag), bus.o_busy, 0);
        check($sformatf("%s.mean_hold", tag), bus.o_mean, exp_mean);
    endtask

    initial begin
        int          cnt;
        int          gap;
        int unsigned exp_mean;
        int unsigned exp_ci;

        rst_n       = 1'b0;
        bus.i_start = 1'b0;
        foreach (cur_win[k]) cur_win[k] = '0;
        bus.i_win = cur_win;
        repeat (3) @(negedge clk);
        check("reset.busy", bus.o_busy, 0);
        check("reset.valid", bus.o_valid, 0);
        check("reset.mean", bus.o_mean, 0);
        check("reset.ci", bus.o_ci, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // All zeros: mean 0, center 0 >= 0.
        do_run("zeros", 1'b0);
        check("zeros.ci_one", bus.o_ci, 1);

        foreach (cur_win[k]) cur_win[k] = 8'd255;
        do_run("max", 1'b0);
        check("max.mean255", bus.o_mean, 255);

        foreach (cur_win[k]) cur_win[k] = W'(k);
        do_run("ramp", 1'b0);
        check("ramp.mean12", bus.o_mean, 12);

        foreach (cur_win[k]) cur_win[k] = 8'd100;
        cur_win[N/2] = 8'd0;
        do_run("center0", 1'b0);
        check("center0.mean96", bus.o_mean, 96);
        cur_win[N/2] = 8'd97;
        do_run("center97", 1'b0);
        check("center97.mean99", bus.o_mean, 99);

        // Random windows; half of them place the center near the mean.
        for (int r = 0; r < 10; r++) begin
            foreach (cur_win[k]) cur_win[k] = W'($urandom_range(0, 255));
            if (r % 2 == 1) cur_win[N/2] = W'(model_mean() + $urandom_range(0, 2) - 1);
            do_run($sformatf("rand%0d", r), 1'b0);
        end

        // Starts during a run are neither restarts nor queued.
        foreach (cur_win[k]) cur_win[k] = W'($urandom_range(50, 200));
        do_run("pulse", 1'b1);
        cnt = 0;
        for (int c = 0; c < 50; c++) begin
            if (bus.o_valid) cnt++;
            @(negedge clk);
        end
        check("pulse.no_extra_valid", cnt, 0);

        // Start held high: next run begins on the single IDLE cycle after DONE.
        foreach (cur_win[k]) cur_win[k] = W'($urandom_range(0, 255));
        bus.i_win = cur_win;
        exp_mean  = model_mean();
        exp_ci    = model_ci();
        @(negedge clk);
        bus.i_start = 1'b1;
        cnt = 0;
        while (!bus.o_valid && cnt < LIMIT) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b.first_valid", bus.o_valid, 1);
        check("b2b.first_mean", bus.o_mean, exp_mean);
        @(negedge clk);
        check("b2b.idle_gap", bus.o_busy, 0);
        gap = 1;
        while (!bus.o_valid && gap < LIMIT) begin
            @(negedge clk);
            gap++;
        end
        bus.i_start = 1'b0;
        check("b2b.gap", gap, LAT + 1);
        check("b2b.second_mean", bus.o_mean, exp_mean);
        check("b2b.second_ci", bus.o_ci, exp_ci);
        @(negedge clk);
        @(negedge clk);
        check("b2b.stopped", bus.o_busy, 0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst_n       = 1'b0;
        bus.i_start = 1'b1;
        @(negedge clk);
        check("rstprio.busy", bus.o_busy, 0);
        rst_n       = 1'b1;
        bus.i_start = 1'b0;
        @(negedge clk);
        check("rstprio.still_idle", bus.o_busy, 0);

        // Leave a nonzero result so the abort visibly clears it.
        foreach (cur_win[k]) cur_win[k] = 8'd100;
        cur_win[N/2] = 8'd200;
        do_run("pre_abort", 1'b0);

        // One-cycle reset during DIV aborts the run without a result.
        @(negedge clk);
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        repeat (29) @(negedge clk);
        check("abort.in_run", bus.o_busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort.busy", bus.o_busy, 0);
        check("abort.valid", bus.o_valid, 0);
        check("abort.mean", bus.o_mean, 0);
        check("abort.ci", bus.o_ci, 0);
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (bus.o_valid) cnt++;
            @(negedge clk);
        end
        check("abort.no_valid", cnt, 0);

        foreach (cur_win[k]) cur_win[k] = W'($urandom_range(0, 255));
        do_run("after_abort", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ci_window_mean.md
CI_WINDOW_MEAN -- requirements
Module: ci_window_mean

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the pixel width.
REQ-002 The block SHALL have parameter SIZE, default 25, giving the number of window elements (odd, at least 3).
REQ-003 The block SHALL define local SUMW = WIDTH + $clog2(SIZE), the accumulator and divider width.
REQ-004 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port i_start, input, 1 bit: request to process the window.
REQ-007 The block SHALL have port i_win, input, WIDTH x SIZE unpacked array: the held window from the upstream hold stage.
REQ-008 The block SHALL have port o_busy, output, 1 bit: the block is processing.
REQ-009 The block SHALL have port o_valid, output, 1 bit: one-cycle result strobe.
REQ-010 The block SHALL have port o_mean, output, WIDTH bits: floor(sum of window / SIZE).
REQ-011 The block SHALL have port o_ci, output, 1 bit: 1 when the center pixel is greater than or equal to o_mean.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, ACC, DIV, DONE.
REQ-013 IDLE: i_start=1 SHALL be accepted; the block SHALL clear sum and index, capture center = i_win[SIZE/2], and go to ACC.
REQ-014 ACC: one element per cycle, sum <= sum + i_win[idx], idx counting 0..SIZE-1; after idx=SIZE-1 the block SHALL go to DIV; SIZE cycles in ACC.
REQ-015 Accumulation SHALL be unsigned, zero-extended to SUMW; no overflow is possible (SIZE*(2^WIDTH-1) < 2^SUMW).
REQ-016 DIV: the block SHALL run a restoring division of sum by the constant SIZE, one quotient bit per cycle, MSB first; SUMW cycles in DIV.
REQ-017 DONE, one cycle: o_mean SHALL take the low WIDTH quotient bits (the quotient is always ≤ 2^WIDTH-1), o_ci SHALL be (center >= o_mean) unsigned, o_valid=1, next state IDLE.
REQ-018 Latency: o_valid SHALL be high in the cycle following edge SIZE+SUMW+1 after the edge sampling i_start (39 cycles for the defaults).
REQ-019 o_busy SHALL be 1 in ACC, DIV and DONE, and 0 in IDLE.
REQ-020 i_start SHALL be ignored while o_busy=1: no restart and no queueing.
REQ-021 i_start held high continuously SHALL start a new run on the first IDLE cycle after DONE, i.e. back-to-back with no gap beyond IDLE.
REQ-022 Upstream SHALL hold i_win stable during ACC; the center value SHALL be used only from the capture made at accept.
REQ-023 o_mean and o_ci SHALL hold their last result until the next DONE; o_valid SHALL be 0 in every other cycle.

Reset
REQ-024 On an i_rst_n=0 sample, the next state SHALL be IDLE with sum, idx, quotient, remainder and center all 0.
REQ-025 On reset, o_busy=0, o_valid=0, o_mean=0 and o_ci=0.
REQ-026 Reset SHALL take priority over i_start in the same cycle.
REQ-027 Reset mid-ACC or mid-DIV SHALL abort the run with no o_valid produced; the next i_start after release SHALL run normally.

Verification
REQ-028 All 25 elements 0, then start -> o_valid at cycle 39, o_mean=0, o_ci=1.
REQ-029 All elements 255 -> sum 6375, o_mean=255, o_ci=1.
REQ-030 Ramp i_win[k]=k for k=0..24 -> sum 300, o_mean=12, center 12, o_ci=1.
REQ-031 Center 0 with all others 100 -> sum 2400, o_mean=96, o_ci=0; a second run with center 97 and the rest unchanged -> o_mean=99 (2497/25), o_ci=0.
REQ-032 i_start pulsed at cycles 5 and 20 of a run -> exactly one o_valid; o_busy stays high throughout.
REQ-033 i_rst_n low for one cycle during DIV -> no o_valid, outputs 0; a fresh start then gives the correct result at the standard latency.
